// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one op in flight, stalls the front of the pipeline until the result is ready.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg;
  logic [CW-1:0]     counter_reg;
  logic [2:0]        f3_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   oper_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   result_reg;

  // Operand decode in IDLE
  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, is_rem, b_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              neg_next;

  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = signed_a & op_a[XLEN-1];
    sign_b   = signed_b & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    is_div   = funct3[2];
    is_rem   = funct3[2] & funct3[1];
    b_zero   = (op_b == '0);
    div_ovf  = funct3[2] & ~funct3[0] &
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
    special  = is_div & (b_zero | div_ovf);
    if (b_zero)
      special_res = funct3[1] ? op_a : '1;
    else
      special_res = funct3[1] ? '0 : op_a;
    neg_next = is_rem ? sign_a : (sign_a ^ sign_b);
  end

  // One iteration of multiply or divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, oper_reg};
    mul_next = prod_reg[0] ? {mul_sum, prod_reg[XLEN-1:1]}
                           : {1'b0, prod_reg[2*XLEN-1:1]};
    // prod_reg holds {remainder, quotient} while dividing
    div_shift = prod_reg[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, oper_reg};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_reg[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], prod_reg[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and word selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_reg ? -prod_reg : prod_reg;
    quot_fix = neg_reg ? -prod_reg[XLEN-1:0] : prod_reg[XLEN-1:0];
    rem_fix  = neg_reg ? -prod_reg[2*XLEN-1:XLEN] : prod_reg[2*XLEN-1:XLEN];
    if (!f3_reg[2])
      fix_res = (f3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      fix_res = f3_reg[1] ? rem_fix : quot_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      counter_reg <= '0;
      f3_reg      <= '0;
      neg_reg     <= 1'b0;
      oper_reg    <= '0;
      prod_reg    <= '0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && !flush) begin
            f3_reg      <= funct3;
            neg_reg     <= neg_next;
            counter_reg <= '0;
            oper_reg    <= is_div ? mag_b : mag_a;
            prod_reg    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (special) begin
              result_reg <= special_res;
              state_reg  <= S_DONE;
            end else begin
              state_reg  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            prod_reg    <= f3_reg[2] ? div_next : mul_next;
            counter_reg <= counter_reg + 1'b1;
            if (counter_reg == LAST_ITER)
              state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush)
            result_reg <= fix_res;
          state_reg <= flush ? S_IDLE : S_DONE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign stall  = ((state_reg == S_IDLE) && start && !flush) ||
                  (state_reg == S_CALC) || (state_reg == S_FIX);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + randomised bench for muldiv_seq; expected results are queued at issue
// and popped when done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic signed [63:0] sa, sb, ub;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue at cycle N (stall must already be high), wait for done, compare latency/result.
  // poke > 0 re-asserts start with junk operands at N+poke while busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke);
    int lat;
    logic stall_ok;
    logic [31:0] e;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    exp_q.push_back(exp);
    #1 check({tag, "_stall_at_issue"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!stall) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        start = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall_held"}, {31'b0, stall_ok}, 32'd1);
    check({tag, "_stall_at_done"}, {31'b0, stall}, 32'd0);
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e);
    $display("txn %s f3=%0d a=%h b=%h result=%h expected=%h latency=%0d",
             tag, f, a, b, result, e, lat);
  endtask

  initial begin
    logic seen_done;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    int rlat;

    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;

    // Multiply
    run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    // Divide
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu",   3'b101, 32'd100,       32'd7, 32'd14,        34, 0);
    run_op("remu",   3'b111, 32'd100,       32'd7, 32'd2,         34, 0);
    // Special divides
    run_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem0",   3'b110, 32'd5,         32'd0,         32'd5,         1, 0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0);

    // Flush at N+10 of a DIV; result must keep 0 from removf
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    seen_done = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done = 1'b1;
      flush = (c == 10);
    end
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_no_done", {31'b0, seen_done}, 32'd0);
    check("flush_result_held", result, 32'h0);
    $display("txn flush div a=%h b=%h result=%h", 32'd1000, 32'd3, result);
    run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 34, 0);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    #1 check("flush_start_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    $display("txn flush_with_start busy=%0d", busy);

    // Start while busy is ignored
    run_op("start_ignored", 3'b000, 32'd6, 32'd7, 32'd42, 34, 3);

    // Reset at N+5 mid-calculation
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = (c == 3);
      reset = (c == 5);
    end
    reset = 1'b0;
    check("midreset_result", result, 32'h0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    $display("txn reset_mid_op result=%h busy=%0d", result, busy);

    // Randomised ops against the reference model
    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = (i == 5) ? 32'd0 : $urandom();
      rlat = (rf[2] && (rb == 0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 1 : 34;
      run_op("rand", rf, ra, rb, ref_op(rf, ra, rb), rlat, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
